// File: rtl/tl_source_shrinker_if.sv
// ---------------------------------------------------------------------------
// tl_source_shrinker_if
//   Bundles the four TileLink-UH channel halves seen by the source shrinker:
//     in_a_*  : upstream A (wide source), agent -> shrinker
//     out_a_* : downstream A (narrow source), shrinker -> slave port
//     out_d_* : downstream D (narrow source), slave port -> shrinker
//     in_d_*  : upstream D (restored source), shrinker -> agent
//   Modport slave  : the shrinker's view.
//   Modport master : the environment's view (drives in_a/out_d, sinks out_a/in_d).
// ---------------------------------------------------------------------------
interface tl_source_shrinker_if #(
   parameter int IN_SOURCE_BITS = 4,
   parameter int OUT_IDS        = 4,
   parameter int BEAT_BYTES     = 8
);
   localparam int OUT_BITS = $clog2(OUT_IDS);

   // upstream A
   logic                      in_a_valid;
   logic                      in_a_ready;
   logic [IN_SOURCE_BITS-1:0] in_a_bits_source;
   logic [2:0]                in_a_bits_opcode;
   logic [2:0]                in_a_bits_param;
   logic [3:0]                in_a_bits_size;
   logic [31:0]               in_a_bits_address;
   logic [BEAT_BYTES-1:0]     in_a_bits_mask;
   logic [8*BEAT_BYTES-1:0]   in_a_bits_data;
   logic                      in_a_bits_corrupt;

   // downstream A
   logic                      out_a_valid;
   logic                      out_a_ready;
   logic [OUT_BITS-1:0]       out_a_bits_source;
   logic [2:0]                out_a_bits_opcode;
   logic [2:0]                out_a_bits_param;
   logic [3:0]                out_a_bits_size;
   logic [31:0]               out_a_bits_address;
   logic [BEAT_BYTES-1:0]     out_a_bits_mask;
   logic [8*BEAT_BYTES-1:0]   out_a_bits_data;
   logic                      out_a_bits_corrupt;

   // downstream D
   logic                      out_d_valid;
   logic                      out_d_ready;
   logic [OUT_BITS-1:0]       out_d_bits_source;
   logic [2:0]                out_d_bits_opcode;
   logic [1:0]                out_d_bits_param;
   logic [3:0]                out_d_bits_size;
   logic [2:0]                out_d_bits_sink;
   logic                      out_d_bits_denied;
   logic [8*BEAT_BYTES-1:0]   out_d_bits_data;
   logic                      out_d_bits_corrupt;

   // upstream D
   logic                      in_d_valid;
   logic                      in_d_ready;
   logic [IN_SOURCE_BITS-1:0] in_d_bits_source;
   logic [2:0]                in_d_bits_opcode;
   logic [1:0]                in_d_bits_param;
   logic [3:0]                in_d_bits_size;
   logic [2:0]                in_d_bits_sink;
   logic                      in_d_bits_denied;
   logic [8*BEAT_BYTES-1:0]   in_d_bits_data;
   logic                      in_d_bits_corrupt;

   modport slave (
      input  in_a_valid, in_a_bits_source, in_a_bits_opcode, in_a_bits_param,
             in_a_bits_size, in_a_bits_address, in_a_bits_mask, in_a_bits_data,
             in_a_bits_corrupt,
      output in_a_ready,
      output out_a_valid, out_a_bits_source, out_a_bits_opcode, out_a_bits_param,
             out_a_bits_size, out_a_bits_address, out_a_bits_mask, out_a_bits_data,
             out_a_bits_corrupt,
      input  out_a_ready,
      input  out_d_valid, out_d_bits_source, out_d_bits_opcode, out_d_bits_param,
             out_d_bits_size, out_d_bits_sink, out_d_bits_denied, out_d_bits_data,
             out_d_bits_corrupt,
      output out_d_ready,
      output in_d_valid, in_d_bits_source, in_d_bits_opcode, in_d_bits_param,
             in_d_bits_size, in_d_bits_sink, in_d_bits_denied, in_d_bits_data,
             in_d_bits_corrupt,
      input  in_d_ready
   );

   modport master (
      output in_a_valid, in_a_bits_source, in_a_bits_opcode, in_a_bits_param,
             in_a_bits_size, in_a_bits_address, in_a_bits_mask, in_a_bits_data,
             in_a_bits_corrupt,
      input  in_a_ready,
      input  out_a_valid, out_a_bits_source, out_a_bits_opcode, out_a_bits_param,
             out_a_bits_size, out_a_bits_address, out_a_bits_mask, out_a_bits_data,
             out_a_bits_corrupt,
      output out_a_ready,
      output out_d_valid, out_d_bits_source, out_d_bits_opcode, out_d_bits_param,
             out_d_bits_size, out_d_bits_sink, out_d_bits_denied, out_d_bits_data,
             out_d_bits_corrupt,
      input  out_d_ready,
      input  in_d_valid, in_d_bits_source, in_d_bits_opcode, in_d_bits_param,
             in_d_bits_size, in_d_bits_sink, in_d_bits_denied, in_d_bits_data,
             in_d_bits_corrupt,
      output in_d_ready
   );
endinterface

// File: rtl/tl_source_shrinker.sv
// ---------------------------------------------------------------------------
// tl_source_shrinker
//   Maps wide upstream TileLink-UH source IDs onto a small out-ID space.
//   Each first A beat allocates the lowest free table entry and records the
//   upstream source; the last D beat for that out-ID frees it, and every D
//   beat has its source restored from the table. A stalls while all entries
//   are busy. Payloads on both channels are combinational passthroughs.
//
//   Ports:
//     clock       : sole clock, rising edge
//     reset       : asynchronous, active-high, clears all state
//     bus         : tl_source_shrinker_if.slave (in_a/out_a/out_d/in_d)
//     inflight    : number of valid table entries
//     err_unalloc : sticky, a D beat fired for an entry that was not valid
//
//   Handshake: a beat transfers on a channel in any cycle where valid and
//   ready are both high at the rising clock edge; valid never depends on the
//   ready of the same channel side it drives.
// ---------------------------------------------------------------------------
module tl_source_shrinker #(
   parameter int IN_SOURCE_BITS = 4,
   parameter int OUT_IDS        = 4,
   parameter int BEAT_BYTES     = 8,
   parameter int MAX_SIZE       = 6
) (
   input  logic                         clock,
   input  logic                         reset,
   tl_source_shrinker_if.slave          bus,
   output logic [$clog2(OUT_IDS+1)-1:0] inflight,
   output logic                         err_unalloc
);
   localparam int OUT_BITS = $clog2(OUT_IDS);
   localparam int INF_W    = $clog2(OUT_IDS + 1);
   localparam int LG_BEAT  = $clog2(BEAT_BYTES);
   localparam int CNT_W    = MAX_SIZE - LG_BEAT;

   // Beats minus one for a message: multi-beat only when it carries data and
   // the transfer is wider than one bus beat.
   function automatic logic [CNT_W-1:0] f_beats_m1(input logic has_data,
                                                   input logic [3:0] size);
      logic [7:0] span;
      span = 8'd0;
      if (has_data && (size > 4'(LG_BEAT)))
         span = (8'd1 << (size - 4'(LG_BEAT))) - 8'd1;
      return span[CNT_W-1:0];
   endfunction

   logic [OUT_IDS-1:0]        r_valid;
   logic [IN_SOURCE_BITS-1:0] r_src [OUT_IDS];
   logic [OUT_BITS-1:0]       r_a_id;
   logic [CNT_W-1:0]          r_a_rem;
   logic [CNT_W-1:0]          r_d_rem;
   logic                      r_err;

   logic [OUT_IDS-1:0]        w_free;
   logic                      w_any_free;
   logic [OUT_BITS-1:0]       w_alloc_id;
   logic                      w_a_first;
   logic                      w_can_go;
   logic                      w_a_fire;
   logic [CNT_W-1:0]          w_a_beats_m1;
   logic                      w_d_fire;
   logic                      w_d_first;
   logic                      w_d_last;
   logic                      w_d_hit;
   logic [CNT_W-1:0]          w_d_beats_m1;
   logic [OUT_IDS-1:0]        w_set;
   logic [OUT_IDS-1:0]        w_clr;
   logic [INF_W-1:0]          w_count;

   assign w_free     = ~r_valid;
   assign w_any_free = |w_free;

   // Lowest-index free entry; scanning downward lets the lowest win.
   always_comb begin
      w_alloc_id = '0;
      for (int i = OUT_IDS - 1; i >= 0; i--) begin
         if (w_free[i]) w_alloc_id = OUT_BITS'(i);
      end
   end

   // ---------------- A channel ----------------
   // Follow-on beats of a burst never need a table entry, so only a first
   // beat can be held back by a full table.
   assign w_a_first    = (r_a_rem == '0);
   assign w_can_go     = !w_a_first || w_any_free;
   assign w_a_beats_m1 = f_beats_m1(!bus.in_a_bits_opcode[2], bus.in_a_bits_size);

   assign bus.out_a_valid        = bus.in_a_valid && w_can_go;
   assign bus.in_a_ready         = bus.out_a_ready && w_can_go;
   assign w_a_fire               = bus.in_a_valid && bus.in_a_ready;
   assign bus.out_a_bits_source  = w_a_first ? w_alloc_id : r_a_id;
   assign bus.out_a_bits_opcode  = bus.in_a_bits_opcode;
   assign bus.out_a_bits_param   = bus.in_a_bits_param;
   assign bus.out_a_bits_size    = bus.in_a_bits_size;
   assign bus.out_a_bits_address = bus.in_a_bits_address;
   assign bus.out_a_bits_mask    = bus.in_a_bits_mask;
   assign bus.out_a_bits_data    = bus.in_a_bits_data;
   assign bus.out_a_bits_corrupt = bus.in_a_bits_corrupt;

   // ---------------- D channel ----------------
   assign w_d_beats_m1 = f_beats_m1(bus.out_d_bits_opcode == 3'd1, bus.out_d_bits_size);
   assign w_d_first    = (r_d_rem == '0);
   assign w_d_last     = w_d_first ? (w_d_beats_m1 == '0) : (r_d_rem == CNT_W'(1));
   assign w_d_hit      = r_valid[bus.out_d_bits_source];

   assign bus.in_d_valid        = bus.out_d_valid;
   assign bus.out_d_ready       = bus.in_d_ready;
   assign w_d_fire              = bus.out_d_valid && bus.in_d_ready;
   assign bus.in_d_bits_source  = r_src[bus.out_d_bits_source];
   assign bus.in_d_bits_opcode  = bus.out_d_bits_opcode;
   assign bus.in_d_bits_param   = bus.out_d_bits_param;
   assign bus.in_d_bits_size    = bus.out_d_bits_size;
   assign bus.in_d_bits_sink    = bus.out_d_bits_sink;
   assign bus.in_d_bits_denied  = bus.out_d_bits_denied;
   assign bus.in_d_bits_data    = bus.out_d_bits_data;
   assign bus.in_d_bits_corrupt = bus.out_d_bits_corrupt;

   // Allocation only ever targets a free entry and freeing only a valid one,
   // so the two masks are disjoint and both apply in the same cycle.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (w_a_fire && w_a_first) w_set[w_alloc_id] = 1'b1;
      if (w_d_fire && w_d_last && w_d_hit) w_clr[bus.out_d_bits_source] = 1'b1;
   end

   always_comb begin
      w_count = '0;
      for (int i = 0; i < OUT_IDS; i++) w_count = w_count + INF_W'(r_valid[i]);
   end

   assign inflight    = w_count;
   assign err_unalloc = r_err;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
         r_a_id  <= '0;
         r_a_rem <= '0;
         r_d_rem <= '0;
         r_err   <= 1'b0;
         for (int i = 0; i < OUT_IDS; i++) r_src[i] <= '0;
      end else begin
         if (w_a_fire) begin
            if (w_a_first) begin
               r_src[w_alloc_id] <= bus.in_a_bits_source;
               r_a_id            <= w_alloc_id;
               r_a_rem           <= w_a_beats_m1;
            end else begin
               r_a_rem <= r_a_rem - CNT_W'(1);
            end
         end
         if (w_d_fire) begin
            r_d_rem <= w_d_first ? w_d_beats_m1 : (r_d_rem - CNT_W'(1));
            if (!w_d_hit) r_err <= 1'b1;
         end
         r_valid <= (r_valid | w_set) & ~w_clr;
      end
   end
endmodule

// File: tb/tb_tl_source_shrinker.sv
// ---------------------------------------------------------------------------
// tb_tl_source_shrinker
//   Directed scenarios with literal expectations, then a randomized phase.
//   A negedge compare process checks every DUT output against a message-level
//   model (table of busy out-IDs, beats left in the current A and D message).
// ---------------------------------------------------------------------------
module tb_tl_source_shrinker;
   // ---------------- clock / reset ----------------
   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] inflight;
   logic       err_unalloc;

   always #5 clock = ~clock;

   tl_source_shrinker_if bus ();

   tl_source_shrinker dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .inflight    (inflight),
      .err_unalloc (err_unalloc)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int n_beats(input bit has_data, input int size);
      if (has_data && size > 3) return 1 << (size - 3);
      return 1;
   endfunction

   // ---------------- reference model ----------------
   bit         m_valid [4];
   logic [3:0] m_src   [4];
   int         m_a_left;
   int         m_a_id;
   int         m_d_left;
   bit         m_err;

   always @(negedge clock) begin
      int free_id;
      int cnt;
      bit burst;
      bit a_go;
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_src[i]   = '0;
         end
         m_a_left = 0;
         m_a_id   = 0;
         m_d_left = 0;
         m_err    = 0;
         check("rst_inflight", inflight, 0);
         check("rst_err", err_unalloc, 0);
         check("rst_a_valid", bus.out_a_valid, bus.in_a_valid);
         check("rst_a_ready", bus.in_a_ready, bus.out_a_ready);
         check("rst_a_src", bus.out_a_bits_source, 0);
      end else begin
         free_id = -1;
         for (int i = 0; i < 4; i++) if (!m_valid[i] && free_id < 0) free_id = i;
         burst = (m_a_left > 0);
         a_go  = burst || (free_id >= 0);
         check("a_valid", bus.out_a_valid, bus.in_a_valid && a_go);
         check("a_ready", bus.in_a_ready, bus.out_a_ready && a_go);
         if (bus.in_a_valid && a_go) begin
            check("a_src", bus.out_a_bits_source, burst ? m_a_id : free_id);
            check("a_opcode", bus.out_a_bits_opcode, bus.in_a_bits_opcode);
            check("a_param", bus.out_a_bits_param, bus.in_a_bits_param);
            check("a_size", bus.out_a_bits_size, bus.in_a_bits_size);
            check("a_addr", bus.out_a_bits_address, bus.in_a_bits_address);
            check("a_mask", bus.out_a_bits_mask, bus.in_a_bits_mask);
            check("a_data", bus.out_a_bits_data, bus.in_a_bits_data);
            check("a_corrupt", bus.out_a_bits_corrupt, bus.in_a_bits_corrupt);
         end
         check("d_valid", bus.in_d_valid, bus.out_d_valid);
         check("d_ready", bus.out_d_ready, bus.in_d_ready);
         if (bus.out_d_valid) begin
            if (m_valid[bus.out_d_bits_source])
               check("d_src", bus.in_d_bits_source, m_src[bus.out_d_bits_source]);
            check("d_opcode", bus.in_d_bits_opcode, bus.out_d_bits_opcode);
            check("d_param", bus.in_d_bits_param, bus.out_d_bits_param);
            check("d_size", bus.in_d_bits_size, bus.out_d_bits_size);
            check("d_sink", bus.in_d_bits_sink, bus.out_d_bits_sink);
            check("d_denied", bus.in_d_bits_denied, bus.out_d_bits_denied);
            check("d_data", bus.in_d_bits_data, bus.out_d_bits_data);
            check("d_corrupt", bus.in_d_bits_corrupt, bus.out_d_bits_corrupt);
         end
         cnt = 0;
         for (int i = 0; i < 4; i++) cnt += int'(m_valid[i]);
         check("inflight", inflight, cnt);
         check("err_unalloc", err_unalloc, m_err);

         // advance the model by what transfers at the coming edge
         if (bus.in_a_valid && a_go && bus.out_a_ready) begin
            if (!burst) begin
               m_valid[free_id] = 1;
               m_src[free_id]   = bus.in_a_bits_source;
               m_a_id           = free_id;
               m_a_left         = n_beats(bus.in_a_bits_opcode <= 3, int'(bus.in_a_bits_size)) - 1;
            end else begin
               m_a_left--;
            end
         end
         if (bus.out_d_valid && bus.in_d_ready) begin
            if (!m_valid[bus.out_d_bits_source]) m_err = 1;
            if (m_d_left == 0) m_d_left = n_beats(bus.out_d_bits_opcode == 1, int'(bus.out_d_bits_size));
            m_d_left--;
            if (m_d_left == 0 && m_valid[bus.out_d_bits_source]) m_valid[bus.out_d_bits_source] = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic drive_a(input logic [2:0] op, input logic [3:0] size, input logic [3:0] src);
      bus.in_a_valid        = 1'b1;
      bus.in_a_bits_opcode  = op;
      bus.in_a_bits_param   = 3'($urandom_range(0, 7));
      bus.in_a_bits_size    = size;
      bus.in_a_bits_source  = src;
      bus.in_a_bits_address = $urandom;
      bus.in_a_bits_mask    = 8'($urandom);
      bus.in_a_bits_data    = {$urandom, $urandom};
      bus.in_a_bits_corrupt = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_d(input logic [2:0] op, input logic [3:0] size, input logic [1:0] id);
      bus.out_d_valid        = 1'b1;
      bus.out_d_bits_opcode  = op;
      bus.out_d_bits_param   = 2'($urandom_range(0, 3));
      bus.out_d_bits_size    = size;
      bus.out_d_bits_source  = id;
      bus.out_d_bits_sink    = 3'($urandom_range(0, 7));
      bus.out_d_bits_denied  = 1'($urandom_range(0, 1));
      bus.out_d_bits_data    = {$urandom, $urandom};
      bus.out_d_bits_corrupt = 1'($urandom_range(0, 1));
   endtask

   // Returns at the negedge before the edge on which the held beat transfers.
   task automatic wait_ready(input bit is_a, input string name);
      int n;
      n = 0;
      @(negedge clock);
      while (!(is_a ? bus.in_a_ready : bus.out_d_ready) && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (n >= 500) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic a_msg(input logic [2:0] op, input logic [3:0] size, input logic [3:0] src,
                        input int exp_id);
      int nb;
      nb = n_beats(op <= 3, int'(size));
      for (int b = 0; b < nb; b++) begin
         tick();
         drive_a(op, size, src);
         wait_ready(1'b1, "a_msg");
         if (exp_id >= 0) check("lit_a_beat_id", bus.out_a_bits_source, exp_id);
      end
      tick();
      bus.in_a_valid = 1'b0;
   endtask

   task automatic d_msg(input logic [2:0] op, input logic [3:0] size, input logic [1:0] id,
                        input int exp_src, input int exp_infl);
      int nb;
      nb = n_beats(op == 1, int'(size));
      for (int b = 0; b < nb; b++) begin
         tick();
         drive_d(op, size, id);
         wait_ready(1'b0, "d_msg");
         if (exp_src >= 0) check("lit_d_beat_src", bus.in_d_bits_source, exp_src);
         if (exp_infl >= 0) check("lit_d_beat_inflight", inflight, exp_infl);
      end
      tick();
      bus.out_d_valid = 1'b0;
   endtask

   // ---------------- random phase state ----------------
   typedef struct {
      logic [1:0] id;
      logic [2:0] op;
      logic [3:0] size;
   } resp_t;
   resp_t pending[$];
   bit    a_done;
   bit    rand_done;

   function automatic logic [2:0] resp_op(input logic [2:0] a_op);
      case (a_op)
         3'd0, 3'd1: return 3'd0;  // Put -> AccessAck
         3'd5:       return 3'd2;  // Hint -> HintAck
         default:    return 3'd1;  // Get/Arith/Logical -> AccessAckData
      endcase
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      check("watchdog_expired", 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      reset           = 1'b1;
      bus.in_a_valid  = 1'b0;
      bus.out_d_valid = 1'b0;
      bus.out_a_ready = 1'b1;
      bus.in_d_ready  = 1'b1;
      drive_a(3'd4, 4'd3, 4'd0);
      bus.in_a_valid = 1'b0;
      drive_d(3'd0, 4'd3, 2'd0);
      bus.out_d_valid = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;

      // single Get, src 9
      a_msg(3'd4, 4'd3, 4'd9, 0);
      @(negedge clock) check("lit_single_inflight", inflight, 1);
      d_msg(3'd1, 4'd3, 2'd0, 9, 1);
      @(negedge clock) check("lit_single_freed", inflight, 0);

      // fill the table, stall a fifth Get, free ID 2
      for (int i = 1; i <= 4; i++) a_msg(3'd4, 4'd3, 4'(i), i - 1);
      tick();
      drive_a(3'd4, 4'd3, 4'd5);
      @(negedge clock);
      check("lit_full_ready", bus.in_a_ready, 0);
      check("lit_full_valid", bus.out_a_valid, 0);
      check("lit_full_inflight", inflight, 4);
      tick();
      drive_d(3'd1, 4'd3, 2'd2);
      @(negedge clock);
      check("lit_no_bypass", bus.in_a_ready, 0);
      check("lit_free_src", bus.in_d_bits_source, 3);
      tick();
      bus.out_d_valid = 1'b0;
      @(negedge clock);
      check("lit_unstall_ready", bus.in_a_ready, 1);
      check("lit_unstall_id", bus.out_a_bits_source, 2);
      tick();
      bus.in_a_valid = 1'b0;
      d_msg(3'd1, 4'd3, 2'd0, 1, 4);
      d_msg(3'd1, 4'd3, 2'd1, 2, 3);
      d_msg(3'd1, 4'd3, 2'd3, 4, 2);
      d_msg(3'd1, 4'd3, 2'd2, 5, 1);
      @(negedge clock) check("lit_drained", inflight, 0);

      // 8-beat PutFull keeps ID 0; the next request gets ID 1
      a_msg(3'd0, 4'd6, 4'd5, 0);
      a_msg(3'd4, 4'd2, 4'd6, 1);
      d_msg(3'd0, 4'd6, 2'd0, 5, 2);
      @(negedge clock) check("lit_put_freed", inflight, 1);
      d_msg(3'd1, 4'd2, 2'd1, 6, 1);

      // Get size 6: entry held through all 8 D beats
      a_msg(3'd4, 4'd6, 4'd7, 0);
      d_msg(3'd1, 4'd6, 2'd0, 7, 1);
      @(negedge clock) check("lit_burst_freed", inflight, 0);

      // D on an unallocated out-ID
      d_msg(3'd0, 4'd3, 2'd3, -1, 0);
      @(negedge clock);
      check("lit_err_set", err_unalloc, 1);
      check("lit_err_table", inflight, 0);
      a_msg(3'd4, 4'd3, 4'd8, 0);
      d_msg(3'd1, 4'd3, 2'd0, 8, 1);
      repeat (3) tick();
      @(negedge clock) check("lit_err_sticky", err_unalloc, 1);

      // reset in the middle of an 8-beat PutFull
      a_msg(3'd4, 4'd3, 4'd11, 0);
      for (int b = 0; b < 4; b++) begin
         tick();
         drive_a(3'd0, 4'd6, 4'd5);
         wait_ready(1'b1, "rst_burst");
      end
      @(posedge clock);
      #1 reset = 1'b1;
      bus.in_a_valid = 1'b0;
      @(negedge clock);
      check("lit_rst_inflight", inflight, 0);
      check("lit_rst_err", err_unalloc, 0);
      @(posedge clock);
      #2 reset = 1'b0;
      a_msg(3'd4, 4'd3, 4'd10, 0);
      @(negedge clock) check("lit_rst_first_beat", inflight, 1);
      d_msg(3'd1, 4'd3, 2'd0, 10, 1);

      // randomized traffic
      a_done    = 0;
      rand_done = 0;
      fork
         begin
            for (int m = 0; m < 250; m++) begin
               logic [2:0] op;
               logic [3:0] size;
               logic [3:0] src;
               logic [1:0] id;
               int nb;
               op   = 3'($urandom_range(0, 5));
               size = 4'($urandom_range(0, 6));
               src  = 4'($urandom_range(0, 15));
               nb   = n_beats(op <= 3, int'(size));
               id   = '0;
               for (int b = 0; b < nb; b++) begin
                  tick();
                  if ($urandom_range(0, 3) == 0) begin
                     bus.in_a_valid = 1'b0;
                     tick();
                  end
                  drive_a(op, size, src);
                  wait_ready(1'b1, "rand_a");
                  if (b == 0) id = bus.out_a_bits_source;
               end
               tick();
               bus.in_a_valid = 1'b0;
               pending.push_back('{id: id, op: resp_op(op), size: size});
            end
            a_done = 1;
         end
         begin
            int guard;
            guard = 0;
            while (!(a_done && pending.size() == 0) && guard < 40000) begin
               tick();
               guard++;
               if (pending.size() != 0 && $urandom_range(0, 2) != 0) begin
                  int idx;
                  int nb;
                  resp_t r;
                  idx = $urandom_range(0, pending.size() - 1);
                  r   = pending[idx];
                  pending.delete(idx);
                  nb  = n_beats(r.op == 1, int'(r.size));
                  for (int b = 0; b < nb; b++) begin
                     if (b != 0) tick();
                     drive_d(r.op, r.size, r.id);
                     wait_ready(1'b0, "rand_d");
                  end
                  tick();
                  bus.out_d_valid = 1'b0;
               end
            end
            if (guard >= 40000) check("rand_d_budget", 0, 1);
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clock);
               #1;
               bus.out_a_ready = ($urandom_range(0, 3) != 0);
               bus.in_d_ready  = ($urandom_range(0, 3) != 0);
            end
            bus.out_a_ready = 1'b1;
            bus.in_d_ready  = 1'b1;
         end
      join

      repeat (2) tick();
      @(negedge clock);
      check("lit_final_inflight", inflight, 0);
      check("lit_final_err", err_unalloc, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
